// File: rtl/spart_send_bridge_pkg.sv
// spart_send_bridge_pkg: shared TX state encoding, RECV address map and loopback command codes
package spart_send_bridge_pkg;
    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_PRESENT = 2'd1,
        TX_GAP     = 2'd2
    } tx_state_e;
    localparam logic [2:0] RA_RXDATA = 3'd0;
    localparam logic [2:0] RA_STATUS = 3'd1;
    localparam logic [2:0] RA_FREE   = 3'd2;
    localparam logic [2:0] RA_CLROVR = 3'd3;
    localparam logic [7:0] LB_CMD_ON  = 8'hF1;
    localparam logic [7:0] LB_CMD_OFF = 8'hF0;
endpackage

// File: rtl/spart_send_bridge_sync_fifo.sv
// sync_fifo: synchronous FIFO; a push while full is refused even if a pop happens in the same cycle
module sync_fifo
    import spart_send_bridge_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = wdata;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spart_send_bridge.sv
// spart_send_bridge: SEND/RECV responder between core and SPART; SPART_BRIDGE_LOOPBACK_EN adds F1/F0 loopback
module spart_send_bridge
    import spart_send_bridge_pkg::*;
#(
    parameter int TX_DEPTH   = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send,
    input  logic        send_sel,
    input  logic [7:0]  send_data,
    output logic        send_stall,
    input  logic [2:0]  spart_addr,
    input  logic        recv,
    output logic [15:0] recv_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_is_cmd,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte
);
    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    logic [8:0]    head;
    logic          full, empty, pop, pop_rx, consume, rx_in_valid;
    logic [7:0]    rx_in_byte;
    logic [CW-1:0] count;
    tx_state_e     state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          rx_full_q, rx_full_d, ovr_q, ovr_d;
    logic [7:0]    rx_hold_q, rx_hold_d;
    sync_fifo #(.WIDTH(9), .DEPTH(TX_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (send),
        .pop   (pop),
        .wdata ({send_sel, send_data}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign send_stall = full;
    assign tx_byte    = head[7:0];
    assign tx_is_cmd  = head[8];
`ifdef SPART_BRIDGE_LOOPBACK_EN
    logic lb_q, lb_d, lb_cmd;
    assign lb_cmd      = head[8] && (head[7:0] == LB_CMD_ON || head[7:0] == LB_CMD_OFF);
    assign consume     = lb_cmd || (lb_q && !head[8]);
    assign rx_in_valid = lb_q ? (state_q == TX_PRESENT && !head[8]) : rx_valid;
    assign rx_in_byte  = lb_q ? head[7:0] : rx_byte;
    always_comb lb_d = (state_q == TX_PRESENT && lb_cmd) ? head[7:0] == LB_CMD_ON : lb_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lb_q <= 1'b0;
        else        lb_q <= lb_d;
    end
`else
    assign consume     = 1'b0;
    assign rx_in_valid = rx_valid;
    assign rx_in_byte  = rx_byte;
`endif
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        tx_valid = 1'b0;
        pop      = 1'b0;
        case (state_q)
            TX_IDLE: if (!empty) state_d = TX_PRESENT;
            TX_PRESENT: begin
                tx_valid = !consume;
                pop      = consume || tx_ready;
                if (pop) begin
                    state_d = GAP_CYCLES > 0 ? TX_GAP : TX_IDLE;
                    gap_d   = GAP_LOAD;
                end
            end
            TX_GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q == '0) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end
    assign pop_rx = recv && spart_addr == RA_RXDATA && rx_full_q;
    always_comb begin
        rx_full_d = rx_full_q;
        rx_hold_d = rx_hold_q;
        ovr_d     = (recv && spart_addr == RA_CLROVR) ? 1'b0 : ovr_q;
        if (rx_in_valid && (!rx_full_q || pop_rx)) begin
            rx_full_d = 1'b1;
            rx_hold_d = rx_in_byte;
        end else if (rx_in_valid) begin
            ovr_d = 1'b1;
        end else if (pop_rx) begin
            rx_full_d = 1'b0;
        end
    end
    assign recv_data = spart_addr == RA_RXDATA ? {rx_full_q, 7'b0, rx_hold_q} :
                       spart_addr == RA_STATUS ? {8'b0, state_q, ovr_q, rx_full_q, full, empty, 2'b0} :
                       spart_addr == RA_FREE   ? 16'(TX_DEPTH) - 16'(count) :
                       spart_addr == RA_CLROVR ? {15'b0, ovr_q} : 16'h0000;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            gap_q     <= '0;
            rx_full_q <= 1'b0;
            rx_hold_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            rx_full_q <= rx_full_d;
            rx_hold_q <= rx_hold_d;
            ovr_q     <= ovr_d;
        end
    end
endmodule
